uart_block_cipher_ctrl: RTL

//  Streams bytes from the UART RX FIFO into a BLOCK_BYTES-wide block and hands each full block to an

---
 rtl/uart_block_cipher_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_block_cipher_ctrl.sv
// UART RX bytes -> cipher block -> UART TX bytes.
// Full blocks issue automatically; a flush pads and issues a partial block.
module uart_block_cipher_ctrl #(
  parameter int         BLOCK_BYTES = 8,
  parameter logic [7:0] PAD_BYTE    = 8'h00,
  parameter int         CNT_W       = 16
) (
  input  logic                     i_clk_100MHz,
  input  logic                     i_reset,
  input  logic [7:0]               i_rx_data,
  input  logic                     i_rx_empty,
  output logic                     o_rx_rd,
  output logic [7:0]               o_tx_data,
  input  logic                     i_tx_full,
  output logic                     o_tx_wr,
  input  logic                     i_flush,
  input  logic                     i_mode_in,
  output logic                     o_core_mode,
  output logic [8*BLOCK_BYTES-1:0] o_core_in,
  output logic                     o_core_start,
  input  logic                     i_core_done,
  input  logic [8*BLOCK_BYTES-1:0] i_core_out,
  output logic                     o_busy,
  output logic [CNT_W-1:0]         o_blocks_done
);

  localparam int BLOCK_W = 8 * BLOCK_BYTES;
  localparam int CW      = $clog2(BLOCK_BYTES + 1);
  localparam int KW      = $clog2(BLOCK_BYTES);

  typedef enum logic [1:0] {
    S_FILL,
    S_ISSUE,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_count;
  logic [KW-1:0]      r_k;
  logic [BLOCK_W-1:0] r_block;
  logic [BLOCK_W-1:0] r_shift;
  logic               r_flush_pend;
  logic               r_mode;
  logic [CNT_W-1:0]   r_blocks;

  logic w_pop;
  logic w_pad;
  logic w_clr_pend;
  logic w_capture;
  logic w_wr;
  logic w_tx_last;

  always_ff @(posedge i_clk_100MHz) begin
    if (i_reset) r_state <= S_FILL;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_pop        = 1'b0;
    w_pad        = 1'b0;
    w_clr_pend   = 1'b0;
    w_capture    = 1'b0;
    w_wr         = 1'b0;
    w_tx_last    = 1'b0;
    o_core_start = 1'b0;
    unique case (r_state)
      S_FILL: begin
        if (r_flush_pend && (r_count != '0)) begin
          w_pad      = 1'b1;
          w_clr_pend = 1'b1;
          w_next     = S_ISSUE;
        end else begin
          w_pop = !i_rx_empty;
          if (w_pop && (r_count == CW'(BLOCK_BYTES - 1)))
            w_next = S_ISSUE;
          // pending flush with nothing buffered and nothing arriving
          if (r_flush_pend && i_rx_empty)
            w_clr_pend = 1'b1;
        end
      end
      S_ISSUE: begin
        o_core_start = 1'b1;
        if (i_core_done) begin
          w_capture = 1'b1;
          w_next    = S_DRAIN;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_core_done) begin
          w_capture = 1'b1;
          w_next    = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_wr = !i_tx_full;
        if (w_wr && (r_k == KW'(BLOCK_BYTES - 1))) begin
          w_tx_last = 1'b1;
          w_next    = S_FILL;
        end
      end
      default: w_next = S_FILL;
    endcase
  end

  always_ff @(posedge i_clk_100MHz) begin
    if (i_reset) begin
      r_count      <= '0;
      r_k          <= '0;
      r_block      <= '0;
      r_shift      <= '0;
      r_flush_pend <= 1'b0;
      r_mode       <= 1'b0;
      r_blocks     <= '0;
    end else begin
      if (i_flush)         r_flush_pend <= 1'b1;
      else if (w_clr_pend) r_flush_pend <= 1'b0;

      for (int i = 0; i < BLOCK_BYTES; i++) begin
        if (w_pop && (r_count == CW'(i)))
          r_block[BLOCK_W-1-8*i -: 8] <= i_rx_data;
        else if (w_pad && (CW'(i) >= r_count))
          r_block[BLOCK_W-1-8*i -: 8] <= PAD_BYTE;
      end

      if (w_pop) r_count <= r_count + CW'(1);

      if (r_state == S_ISSUE) r_mode <= i_mode_in;

      if (w_capture) begin
        r_shift <= i_core_out;
        r_k     <= '0;
      end else if (w_wr) begin
        r_shift <= {r_shift[BLOCK_W-9:0], 8'h00};
        r_k     <= r_k + KW'(1);
      end

      if (w_tx_last) begin
        r_k      <= '0;
        r_count  <= '0;
        r_blocks <= r_blocks + CNT_W'(1);
      end
    end
  end

  // the core sees the live mode during the start cycle, then the latched one
  assign o_core_mode   = (r_state == S_ISSUE) ? i_mode_in : r_mode;
  assign o_core_in     = r_block;
  assign o_rx_rd       = w_pop;
  assign o_tx_wr       = w_wr;
  assign o_tx_data     = r_shift[BLOCK_W-1 -: 8];
  assign o_busy        = (r_state != S_FILL);
  assign o_blocks_done = r_blocks;

endmodule
